// File: rtl/calc_sched_pkg.sv
// calc_sched_pkg: calculator opcodes, scheduler FSM states and opcode support check.
package calc_sched_pkg;

  localparam int unsigned OPW = 3;

  localparam logic [OPW-1:0] OP_SUM  = 3'd1;
  localparam logic [OPW-1:0] OP_MULT = 3'd2;
  localparam logic [OPW-1:0] OP_SUB  = 3'd3;
  localparam logic [OPW-1:0] OP_SQRT = 3'd4;
  localparam logic [OPW-1:0] OP_DIV  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } calc_sched_state_t;

  // DIV is excluded: the datapath returns zero for it.
  function automatic logic is_supported(input logic [OPW-1:0] opcode);
    return (opcode >= OP_SUM) && (opcode <= OP_SQRT);
  endfunction

endpackage

// File: rtl/calc_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last+1 (mod N).
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] w_idx;

  // Scan farthest-to-nearest so the nearest requester after 'last' wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IW'((32'(last) + N - k) % N);
      if (req[w_idx]) begin
        grant        = '0;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/calc_sched.sv
// calc_sched: round-robin scheduler sharing one calculator between NREQ requesters.
// Optional CALC_SCHED_STATS_EN adds stat_ops/stat_errs response counters.
module calc_sched
  import calc_sched_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                calc_clock,
  input  logic                calc_rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [3*NREQ-1:0]   req_opcode,
  input  logic [DW*NREQ-1:0]  req_op1,
  input  logic [DW*NREQ-1:0]  req_op2,
  input  logic [NREQ-1:0]     req_sel,
  output logic [2:0]          calc_opcode,
  output logic [DW-1:0]       calc_op_in1,
  output logic [DW-1:0]       calc_op_in2,
  output logic                calc_op_in_sel,
  input  logic [2*DW-1:0]     calc_result,
  input  logic                calc_valid_res,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*DW-1:0]     rsp_data,
  output logic                rsp_err,
  output logic                busy
`ifdef CALC_SCHED_STATS_EN
  ,
  output logic [31:0]         stat_ops,
  output logic [31:0]         stat_errs
`endif
);

  calc_sched_state_t r_state, w_next;

  logic [IDW-1:0]  r_last_grant;
  logic [2:0]      r_opcode;
  logic [DW-1:0]   r_op1, r_op2;
  logic            r_sel;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gidx;
  logic            w_accept;
  logic            w_drive;
  logic [2:0]      w_sel_opcode, w_hold_opcode;
  logic [DW-1:0]   w_sel_op1, w_sel_op2, w_hold_op1, w_hold_op2;
  logic            w_sel_sel, w_hold_sel;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
    .req       (req_valid),
    .last      (r_last_grant),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  // Select the winning requester's payload.
  always_comb begin
    w_sel_opcode = '0;
    w_sel_op1    = '0;
    w_sel_op2    = '0;
    w_sel_sel    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gidx == IDW'(i)) begin
        w_sel_opcode = req_opcode[3*i +: 3];
        w_sel_op1    = req_op1[DW*i +: DW];
        w_sel_op2    = req_op2[DW*i +: DW];
        w_sel_sel    = req_sel[i];
      end
    end
  end

  // Next state, accept strobe and combinational ready.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    req_ready = '0;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_accept  = 1'b1;
          req_ready = w_grant;
          w_next    = is_supported(w_sel_opcode) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_RESP;
      ST_RESP:    if (rsp_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Values the calculator sees next cycle: fresh payload on accept, else held.
  always_comb begin
    w_hold_opcode = w_accept ? w_sel_opcode : r_opcode;
    w_hold_op1    = w_accept ? w_sel_op1    : r_op1;
    w_hold_op2    = w_accept ? w_sel_op2    : r_op2;
    w_hold_sel    = w_accept ? w_sel_sel    : r_sel;
    w_drive       = (w_next == ST_ISSUE) || (w_next == ST_CAPTURE);
  end

  // State register.
  always_ff @(posedge calc_clock) begin
    if (calc_rst) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Holding registers, calculator drive and response registers.
  always_ff @(posedge calc_clock) begin
    if (calc_rst) begin
      r_last_grant   <= IDW'(NREQ - 1);
      r_opcode       <= '0;
      r_op1          <= '0;
      r_op2          <= '0;
      r_sel          <= 1'b0;
      calc_opcode    <= '0;
      calc_op_in1    <= '0;
      calc_op_in2    <= '0;
      calc_op_in_sel <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      r_opcode       <= w_hold_opcode;
      r_op1          <= w_hold_op1;
      r_op2          <= w_hold_op2;
      r_sel          <= w_hold_sel;
      calc_opcode    <= w_drive ? w_hold_opcode : 3'd0;
      calc_op_in1    <= w_drive ? w_hold_op1 : '0;
      calc_op_in2    <= w_drive ? w_hold_op2 : '0;
      calc_op_in_sel <= w_drive ? w_hold_sel : 1'b0;
      rsp_valid      <= (w_next == ST_RESP);
      busy           <= (w_next != ST_IDLE);
      if (w_accept) begin
        r_last_grant <= w_gidx;
        rsp_id       <= w_gidx;
        if (!is_supported(w_sel_opcode)) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (r_state == ST_CAPTURE) begin
        rsp_data <= calc_result;
        rsp_err  <= ~calc_valid_res;
      end
    end
  end

`ifdef CALC_SCHED_STATS_EN
  // Completed-response and error-response counters.
  always_ff @(posedge calc_clock) begin
    if (calc_rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (rsp_valid && rsp_ready) begin
      stat_ops <= stat_ops + 32'd1;
      if (rsp_err) stat_errs <= stat_errs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_calc_sched.sv
// tb_calc_sched: directed self-checking bench for calc_sched with a calculator model.
module tb_calc_sched;

  localparam int unsigned DW   = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                clk = 1'b0;
  logic                calc_rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [3*NREQ-1:0]   req_opcode;
  logic [DW*NREQ-1:0]  req_op1, req_op2;
  logic [NREQ-1:0]     req_sel;
  logic [2:0]          calc_opcode;
  logic [DW-1:0]       calc_op_in1, calc_op_in2;
  logic                calc_op_in_sel;
  logic [2*DW-1:0]     calc_result = '0;
  logic                calc_valid_res = 1'b0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [IDW-1:0]      rsp_id;
  logic [2*DW-1:0]     rsp_data;
  logic                rsp_err;
  logic                busy;
`ifdef CALC_SCHED_STATS_EN
  logic [31:0]         stat_ops, stat_errs;
`endif

  logic [2:0]    t_op  [NREQ];
  logic [DW-1:0] t_a   [NREQ];
  logic [DW-1:0] t_b   [NREQ];
  logic          t_sel [NREQ];

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  logic saw_bad_op = 1'b0;

  for (genvar g = 0; g < NREQ; g++) begin : g_flat
    assign req_opcode[3*g +: 3] = t_op[g];
    assign req_op1[DW*g +: DW]  = t_a[g];
    assign req_op2[DW*g +: DW]  = t_b[g];
    assign req_sel[g]           = t_sel[g];
  end

  calc_sched #(.DW(DW), .NREQ(NREQ), .IDW(IDW)) dut (
    .calc_clock     (clk),
    .calc_rst       (calc_rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_opcode     (req_opcode),
    .req_op1        (req_op1),
    .req_op2        (req_op2),
    .req_sel        (req_sel),
    .calc_opcode    (calc_opcode),
    .calc_op_in1    (calc_op_in1),
    .calc_op_in2    (calc_op_in2),
    .calc_op_in_sel (calc_op_in_sel),
    .calc_result    (calc_result),
    .calc_valid_res (calc_valid_res),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .busy           (busy)
`ifdef CALC_SCHED_STATS_EN
    ,
    .stat_ops       (stat_ops),
    .stat_errs      (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unsupported opcodes must never reach the calculator.
  always @(posedge clk) if (calc_opcode >= 3'd5) saw_bad_op <= 1'b1;

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    logic [31:0] r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  // Calculator behaviour: {valid_res, result}; overflow gives result 0, valid 0.
  function automatic logic [64:0] calc_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic sel);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      3'd1:    return s[32] ? 65'd0 : {1'b1, 32'd0, s[31:0]};
      3'd2:    return {1'b1, 64'(a) * 64'(b)};
      3'd3:    return (a < b) ? 65'd0 : {1'b1, 32'd0, a - b};
      3'd4:    return {1'b1, 32'd0, isqrt(sel ? a : b)};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  always @(posedge clk) {calc_valid_res, calc_result} <= calc_model(calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic sel);
    t_op[i] = op; t_a[i] = a; t_b[i] = b; t_sel[i] = sel;
    req_valid[i] = 1'b1;
  endtask

  // Called just after the accept edge; returns cycles from accept to rsp_valid, -1 on timeout.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick;
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < NREQ; i++) drive_req(i, 3'd0, 32'd0, 32'd0, 1'b0);
    req_valid = '0;
    rsp_ready = 1'b1;
    calc_rst  = 1'b1;
    tick; tick;
    calc_rst = 1'b0;
    n_total++; if ({req_ready, rsp_valid, rsp_id, rsp_err, busy} !== '0) $display("FAIL reset_ctrl: got %b want 0", {req_ready, rsp_valid, rsp_id, rsp_err, busy}); else n_pass++;
    n_total++; if (rsp_data !== 64'd0) $display("FAIL reset_data: got %h want 0", rsp_data); else n_pass++;
    n_total++; if ({calc_opcode, calc_op_in_sel, calc_op_in1, calc_op_in2} !== '0) $display("FAIL reset_calc: got op %0d in1 %h in2 %h sel %b want 0", calc_opcode, calc_op_in1, calc_op_in2, calc_op_in_sel); else n_pass++;
  endtask

  task automatic test_sum;
    int lat;
    drive_req(0, 3'd1, 32'd3, 32'd5, 1'b0);
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL sum_ready: got %b want 0001", req_ready); else n_pass++;
    tick; req_valid = '0;
    n_total++; if ({busy, calc_opcode, calc_op_in1, calc_op_in2} !== {1'b1, 3'd1, 32'd3, 32'd5}) $display("FAIL sum_issue: got busy %b op %0d in1 %0d in2 %0d want 1 1 3 5", busy, calc_opcode, calc_op_in1, calc_op_in2); else n_pass++;
    wait_rsp(lat);
    n_total++; if (lat !== 3) $display("FAIL sum_latency: got %0d want 3", lat); else n_pass++;
    n_total++; if ({rsp_id, rsp_err, rsp_data} !== {2'd0, 1'b0, 64'd8}) $display("FAIL sum_rsp: got id %0d err %b data %h want 0 0 8", rsp_id, rsp_err, rsp_data); else n_pass++;
    tick;
    n_total++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL sum_idle: got valid/busy %b want 00", {rsp_valid, busy}); else n_pass++;
  endtask

  task automatic test_mult;
    int lat;
    drive_req(2, 3'd2, 32'h0001_0000, 32'h0001_0000, 1'b0);
    #1;
    n_total++; if (req_ready !== 4'b0100) $display("FAIL mult_ready: got %b want 0100", req_ready); else n_pass++;
    tick; req_valid = '0;
    wait_rsp(lat);
    n_total++; if (lat !== 3) $display("FAIL mult_latency: got %0d want 3", lat); else n_pass++;
    n_total++; if ({rsp_id, rsp_err, rsp_data} !== {2'd2, 1'b0, 64'h0000_0001_0000_0000}) $display("FAIL mult_rsp: got id %0d err %b data %h want 2 0 0000000100000000", rsp_id, rsp_err, rsp_data); else n_pass++;
    tick;
  endtask

  task automatic test_overflow;
    int lat;
    drive_req(1, 3'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tick; req_valid = '0;
    wait_rsp(lat);
    n_total++; if (lat !== 3) $display("FAIL ovf_latency: got %0d want 3", lat); else n_pass++;
    n_total++; if ({rsp_id, rsp_err, rsp_data} !== {2'd1, 1'b1, 64'd0}) $display("FAIL ovf_rsp: got id %0d err %b data %h want 1 1 0", rsp_id, rsp_err, rsp_data); else n_pass++;
    tick;
  endtask

  task automatic test_unsupported;
    int lat;
    drive_req(3, 3'd5, 32'd7, 32'd2, 1'b0);
    #1;
    n_total++; if (req_ready !== 4'b1000) $display("FAIL div_ready: got %b want 1000", req_ready); else n_pass++;
    tick; req_valid = '0;
    wait_rsp(lat);
    n_total++; if (lat !== 1) $display("FAIL div_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if ({rsp_id, rsp_err, rsp_data, calc_opcode} !== {2'd3, 1'b1, 64'd0, 3'd0}) $display("FAIL div_rsp: got id %0d err %b data %h calc_op %0d want 3 1 0 0", rsp_id, rsp_err, rsp_data, calc_opcode); else n_pass++;
    tick;
    drive_req(0, 3'd0, 32'd1, 32'd1, 1'b0);
    tick; req_valid = '0;
    wait_rsp(lat);
    n_total++; if ({lat == 1, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd0, 1'b1, 64'd0}) $display("FAIL op0_rsp: got lat %0d id %0d err %b data %h want 1 0 1 0", lat, rsp_id, rsp_err, rsp_data); else n_pass++;
    tick;
    n_total++; if (saw_bad_op !== 1'b0) $display("FAIL no_div_issue: got %b want 0", saw_bad_op); else n_pass++;
  endtask

  task automatic test_sub_sqrt;
    int lat;
    drive_req(1, 3'd3, 32'd10, 32'd3, 1'b0);
    tick; req_valid = '0;
    wait_rsp(lat);
    n_total++; if ({lat == 3, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd1, 1'b0, 64'd7}) $display("FAIL sub_rsp: got lat %0d id %0d err %b data %h want 3 1 0 7", lat, rsp_id, rsp_err, rsp_data); else n_pass++;
    tick;
    drive_req(2, 3'd4, 32'd49, 32'd16, 1'b1);
    tick; req_valid = '0;
    wait_rsp(lat);
    n_total++; if ({lat == 3, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd2, 1'b0, 64'd7}) $display("FAIL sqrt_rsp: got lat %0d id %0d err %b data %h want 3 2 0 7", lat, rsp_id, rsp_err, rsp_data); else n_pass++;
    tick;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [5];
    int t_prev, b;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    calc_rst = 1'b1;
    for (int i = 0; i < NREQ; i++) drive_req(i, 3'd1, 32'(i), 32'd1, 1'b0);
    tick;
    calc_rst = 1'b0;
    t_prev = 0;
    for (int n = 0; n < 5; n++) begin
      b = 0;
      while (req_ready == '0 && b < 20) begin tick; b++; end
      n_total++; if (req_ready !== exp_g[n]) $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, exp_g[n]); else n_pass++;
      if (n > 0) begin
        n_total++; if (cyc - t_prev !== 4) $display("FAIL rr_spacing%0d: got %0d want 4", n, cyc - t_prev); else n_pass++;
      end
      t_prev = cyc;
      tick;
    end
    req_valid = '0;
    b = 0;
    while (busy && b < 20) begin tick; b++; end
    n_total++; if (busy !== 1'b0) $display("FAIL rr_drain: got busy %b want 0", busy); else n_pass++;
  endtask

  task automatic test_backpressure;
    int lat, bad;
    rsp_ready = 1'b0;
    drive_req(0, 3'd1, 32'd100, 32'd23, 1'b0);
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL bp_ready: got %b want 0001", req_ready); else n_pass++;
    tick; req_valid = '0;
    drive_req(1, 3'd1, 32'd1, 32'd1, 1'b0);
    bad = 0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (req_ready != '0) bad++;
      tick; lat++;
    end
    n_total++; if (lat !== 3) $display("FAIL bp_latency: got %0d want 3", lat); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      if (!(rsp_valid === 1'b1 && rsp_data === 64'd123 && rsp_id === 2'd0 && rsp_err === 1'b0 && req_ready === 4'b0000)) bad++;
      tick;
    end
    n_total++; if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
    n_total++; if ({rsp_valid, rsp_data} !== {1'b1, 64'd123}) $display("FAIL bp_still_valid: got %b %h want 1 123", rsp_valid, rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    tick;
    n_total++; if (req_ready !== 4'b0010) $display("FAIL bp_next_grant: got %b want 0010", req_ready); else n_pass++;
    tick; req_valid = '0;
    wait_rsp(lat);
    n_total++; if ({lat == 3, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd1, 1'b0, 64'd2}) $display("FAIL bp_after: got lat %0d id %0d err %b data %h want 3 1 0 2", lat, rsp_id, rsp_err, rsp_data); else n_pass++;
    tick;
  endtask

  task automatic test_reset_capture;
    int lat, seen;
    drive_req(2, 3'd1, 32'd4, 32'd4, 1'b0);
    tick; req_valid = '0;
    tick;
    n_total++; if ({busy, rsp_valid, calc_opcode} !== {1'b1, 1'b0, 3'd1}) $display("FAIL rc_capture: got busy %b valid %b op %0d want 1 0 1", busy, rsp_valid, calc_opcode); else n_pass++;
    calc_rst = 1'b1;
    tick;
    calc_rst = 1'b0;
    n_total++; if ({req_ready, rsp_valid, rsp_id, rsp_err, busy, calc_opcode, calc_op_in_sel, calc_op_in1, calc_op_in2, rsp_data} !== '0) $display("FAIL rc_reset_outputs: got busy %b valid %b op %0d in1 %h data %h want all 0", busy, rsp_valid, calc_opcode, calc_op_in1, rsp_data); else n_pass++;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen++;
      tick;
    end
    n_total++; if (seen !== 0) $display("FAIL rc_no_response: got %0d valid cycles want 0", seen); else n_pass++;
    drive_req(3, 3'd3, 32'd9, 32'd1, 1'b0);
    drive_req(0, 3'd1, 32'd2, 32'd2, 1'b0);
    #1;
    n_total++; if (req_ready !== 4'b0001) $display("FAIL rc_first_grant: got %b want 0001", req_ready); else n_pass++;
    tick; req_valid = '0;
    wait_rsp(lat);
    n_total++; if ({lat == 3, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd0, 1'b0, 64'd4}) $display("FAIL rc_after: got lat %0d id %0d err %b data %h want 3 0 0 4", lat, rsp_id, rsp_err, rsp_data); else n_pass++;
    tick;
  endtask

`ifdef CALC_SCHED_STATS_EN
  task automatic test_stats;
    int lat;
    logic [2:0]  s_op [5];
    logic [31:0] s_a  [5];
    s_op[0] = 3'd1; s_a[0] = 32'd1;
    s_op[1] = 3'd1; s_a[1] = 32'hFFFF_FFFF;
    s_op[2] = 3'd2; s_a[2] = 32'd6;
    s_op[3] = 3'd1; s_a[3] = 32'hFFFF_FFFF;
    s_op[4] = 3'd4; s_a[4] = 32'd81;
    calc_rst = 1'b1;
    tick;
    calc_rst = 1'b0;
    n_total++; if ({stat_ops, stat_errs} !== 64'd0) $display("FAIL stats_reset: got %0d %0d want 0 0", stat_ops, stat_errs); else n_pass++;
    for (int n = 0; n < 5; n++) begin
      drive_req(0, s_op[n], s_a[n], 32'd1, 1'b1);
      tick; req_valid = '0;
      wait_rsp(lat);
      tick;
    end
    n_total++; if (stat_ops !== 32'd5) $display("FAIL stats_ops: got %0d want 5", stat_ops); else n_pass++;
    n_total++; if (stat_errs !== 32'd2) $display("FAIL stats_errs: got %0d want 2", stat_errs); else n_pass++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_sum;
    test_mult;
    test_overflow;
    test_unsupported;
    test_sub_sqrt;
    test_round_robin;
    test_backpressure;
    test_reset_capture;
`ifdef CALC_SCHED_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
